// File: rtl/dac_pkg.sv
// Shared constants and mode encodings for the DAC waveform generator.
package dac_pkg;

    localparam int DAC_W = 12;
    localparam logic [DAC_W-1:0] DAC_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        MODE_DC  = 2'b00,
        MODE_SAW = 2'b01,
        MODE_TRI = 2'b10,
        MODE_SQR = 2'b11
    } dac_mode_e;

endpackage

// File: rtl/dac_tick_div.sv
// Parameterised prescaler: counts enabled cycles and emits a one-cycle tick
// on every DIV-th one. A synchronous clear rewinds the count to zero.
module dac_tick_div #(
    parameter int DIV = 2
) (
    input  logic i_clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign o_tick = i_en & ~i_clr & (cnt == LAST);

    // Cycle counter: cleared on i_clr, otherwise wraps at DIV-1 while enabled.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_wave_gen.sv
// DAC sample source: DC, sawtooth, triangle or square codes generated at a
// programmable tick rate and offered to the I2C writer over valid/ready.
//
// Handshake: o_valid high means o_code holds a sample not yet taken; o_code is
// frozen until a transfer (o_valid & i_ready on a clock edge). A tick while a
// sample is still pending (no transfer that cycle) drops the new sample and
// flags o_overrun; a tick on the transfer cycle itself reloads without a gap.
module dac_wave_gen
    import dac_pkg::*;
#(
    parameter int TICK_DIV = 2500
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic [DAC_W-1:0] i_step,
    input  logic [DAC_W-1:0] i_level,
    output logic [DAC_W-1:0] o_code,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun,
    input  logic             i_clr_overrun
);

    logic             tick;
    logic             xfer;
    logic             ovr_evt;
    dac_mode_e        mode;
    logic [DAC_W-1:0] phase;
    logic [DAC_W-1:0] phase_nxt;
    logic [DAC_W-1:0] code_nxt;
    logic [DAC_W:0]   sum;
    logic             dir_down;
    logic             dir_down_nxt;

    dac_tick_div #(
        .DIV(TICK_DIV)
    ) u_tick_div (
        .i_clk  (i_clk),
        .reset  (reset),
        .i_en   (i_enable),
        .i_clr  (~i_enable),
        .o_tick (tick)
    );

    assign mode    = dac_mode_e'(i_mode);
    assign xfer    = o_valid & i_ready;
    assign ovr_evt = tick & o_valid & ~i_ready;

    // Next phase/direction and the code derived from the updated phase.
    always_comb begin
        sum          = {1'b0, phase} + {1'b0, i_step};
        phase_nxt    = sum[DAC_W-1:0];
        dir_down_nxt = dir_down;
        code_nxt     = '0;
        if (mode == MODE_TRI) begin
            if (!dir_down) begin
                if (sum >= {1'b0, DAC_MAX}) begin
                    phase_nxt    = DAC_MAX;
                    dir_down_nxt = 1'b1;
                end
            end else if (phase <= i_step) begin
                phase_nxt    = '0;
                dir_down_nxt = 1'b0;
            end else begin
                phase_nxt = phase - i_step;
            end
        end
        case (mode)
            MODE_DC:  code_nxt = i_level;
            MODE_SQR: code_nxt = phase_nxt[DAC_W-1] ? i_level : '0;
            default:  code_nxt = phase_nxt;
        endcase
    end

    // Phase accumulator and triangle direction; rewound while disabled.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            phase    <= '0;
            dir_down <= 1'b0;
        end else if (!i_enable) begin
            phase    <= '0;
            dir_down <= 1'b0;
        end else if (tick) begin
            phase    <= phase_nxt;
            dir_down <= dir_down_nxt;
        end
    end

    // Output sample register: load on tick if the slot is free or being
    // emptied this cycle, otherwise release the slot on transfer.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            o_code  <= '0;
            o_valid <= 1'b0;
        end else if (tick && (!o_valid || i_ready)) begin
            o_code  <= code_nxt;
            o_valid <= 1'b1;
        end else if (xfer) begin
            o_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new overrun wins over a simultaneous clear.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            o_overrun <= 1'b0;
        end else if (ovr_evt) begin
            o_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            o_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Testbench for dac_wave_gen: directed scenarios followed by randomized
// traffic, checked cycle by cycle against a queue-based reference model.
module tb_dac_wave_gen;

    localparam int TD = 4;

    logic        i_clk;
    logic        reset;
    logic        i_enable;
    logic [1:0]  i_mode;
    logic [11:0] i_step;
    logic [11:0] i_level;
    logic [11:0] o_code;
    logic        o_valid;
    logic        i_ready;
    logic        o_overrun;
    logic        i_clr_overrun;

    dac_wave_gen #(
        .TICK_DIV(TD)
    ) dut (
        .i_clk         (i_clk),
        .reset         (reset),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .i_step        (i_step),
        .i_level       (i_level),
        .o_code        (o_code),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_overrun     (o_overrun),
        .i_clr_overrun (i_clr_overrun)
    );

    // Clock and reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Scoreboard and reference model state
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    int          m_phase;
    bit          m_down;
    int          en_cnt;
    bit          exp_ovr;
    int          n_vec;
    int          n_err;

    int saw_exp [5] = '{1024, 2048, 3072, 0, 1024};
    int tri_exp [7] = '{1500, 3000, 4095, 2595, 1095, 0, 1500};
    int sqr_exp [6] = '{0, 2000, 2000, 0, 0, 2000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_phase = 0;
        m_down  = 1'b0;
        en_cnt  = 0;
        exp_ovr = 1'b0;
    endtask

    // One sample computed straight from the waveform rules on the current inputs.
    task automatic ref_sample(output logic [11:0] c);
        int s;
        s = m_phase + int'(i_step);
        if (i_mode == 2'd2) begin
            if (!m_down) begin
                if (s >= 4095) begin
                    m_phase = 4095;
                    m_down  = 1'b1;
                end else begin
                    m_phase = s;
                end
            end else if (m_phase <= int'(i_step)) begin
                m_phase = 0;
                m_down  = 1'b0;
            end else begin
                m_phase = m_phase - int'(i_step);
            end
        end else begin
            m_phase = s % 4096;
        end
        case (i_mode)
            2'd0:    c = i_level;
            2'd3:    c = (m_phase >= 2048) ? i_level : 12'd0;
            default: c = 12'(m_phase);
        endcase
    endtask

    // Advance one clock: update the model from the inputs in force, then check.
    task automatic tick_clk();
        bit          tk;
        bit          xf;
        bit          ev;
        logic [11:0] c;
        tk = (i_enable === 1'b1) && (en_cnt == TD - 1);
        xf = (exp_q.size() != 0) && (i_ready === 1'b1);
        ev = tk && (exp_q.size() != 0) && !xf;
        if (xf) begin
            got_q.push_back(o_code);
            void'(exp_q.pop_front());
        end
        if (tk) begin
            ref_sample(c);
            if (!ev) exp_q.push_back(c);
        end
        if (ev) exp_ovr = 1'b1;
        else if (i_clr_overrun) exp_ovr = 1'b0;
        if (i_enable !== 1'b1) begin
            en_cnt  = 0;
            m_phase = 0;
            m_down  = 1'b0;
        end else begin
            en_cnt = (en_cnt + 1) % TD;
        end
        @(posedge i_clk);
        #1;
        chk("valid", 32'(o_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("code", 32'(o_code), 32'(exp_q[0]));
        chk("overrun", 32'(o_overrun), 32'(exp_ovr));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick_clk();
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [11:0] step, input logic [11:0] level);
        i_mode  = mode;
        i_step  = step;
        i_level = level;
    endtask

    task automatic rewind();
        i_enable = 1'b0;
        run(1);
        got_q.delete();
    endtask

    // Directed scenarios, then randomized traffic, then the report.
    initial begin
        n_vec = 0;
        n_err = 0;
        model_clear();
        got_q.delete();
        reset         = 1'b1;
        i_enable      = 1'b0;
        i_ready       = 1'b0;
        i_clr_overrun = 1'b0;
        set_cfg(2'd0, 12'd0, 12'd0);
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_code", 32'(o_code), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        reset = 1'b0;

        // Sawtooth
        set_cfg(2'd1, 12'd1024, 12'd0);
        i_ready  = 1'b1;
        rewind();
        i_enable = 1'b1;
        run(22);
        chk("saw_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("saw_%0d", i), 32'(got_q[i]), 32'(saw_exp[i]));

        // Triangle
        set_cfg(2'd2, 12'd1500, 12'd0);
        rewind();
        i_enable = 1'b1;
        run(30);
        chk("tri_count", 32'(got_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk($sformatf("tri_%0d", i), 32'(got_q[i]), 32'(tri_exp[i]));

        // Square
        set_cfg(2'd3, 12'd1024, 12'd2000);
        rewind();
        i_enable = 1'b1;
        run(26);
        chk("sqr_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("sqr_%0d", i), 32'(got_q[i]), 32'(sqr_exp[i]));

        // Backpressure over three ticks
        set_cfg(2'd1, 12'd100, 12'd0);
        rewind();
        i_ready  = 1'b0;
        i_enable = 1'b1;
        run(12);
        chk("bp_hold_code", 32'(o_code), 32'd100);
        chk("bp_overrun", 32'(o_overrun), 32'd1);
        i_ready = 1'b1;
        run(6);
        chk("bp_count", 32'(got_q.size()), 32'd2);
        chk("bp_first", 32'(got_q[0]), 32'd100);
        chk("bp_next", 32'(got_q[1]), 32'd400);
        i_clr_overrun = 1'b1;
        run(1);
        i_clr_overrun = 1'b0;
        chk("bp_cleared", 32'(o_overrun), 32'd0);

        // Enable drop with a pending sample, then re-enable
        i_ready = 1'b0;
        run(4);
        i_enable = 1'b0;
        run(6);
        got_q.delete();
        i_ready = 1'b1;
        run(9);
        chk("drop_delivered", 32'(got_q.size()), 32'd1);
        got_q.delete();
        set_cfg(2'd1, 12'd77, 12'd0);
        i_enable = 1'b1;
        run(5);
        chk("reen_first", 32'(got_q[0]), 32'd77);

        // Asynchronous reset with a sample pending and overrun set
        i_ready = 1'b0;
        run(12);
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_code", 32'(o_code), 32'd0);
        chk("arst_overrun", 32'(o_overrun), 32'd0);
        model_clear();
        @(posedge i_clk);
        #1;
        reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (n % 40 == 0) begin
                i_mode  = 2'($urandom_range(0, 3));
                i_step  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
                i_level = 12'($urandom_range(0, 4095));
            end
            i_enable      = ($urandom_range(0, 29) != 0);
            i_ready       = ($urandom_range(0, 3) != 0);
            i_clr_overrun = ($urandom_range(0, 15) == 0);
            tick_clk();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
